sync_fifo_param: RTL
====================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the team's 8-bit sync FIFO.
//  Adds generic width/depth, programmable almost-full/almost-empty thresholds,
//  an occupancy count, a first-word-fall-through (FWFT) mode, synchronous flush
//  and sticky overflow/underflow flags. Buffers streams between same-clock stages.
// PARAMETERS
//  WIDTH      8   data word width in bits
//  DEPTH      16  number of entries; power of 2, >= 4
//  AF_THRESH  12  almost_full asserts when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH  2   almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
//  FWFT       0   0 = standard read, 1 = first-word-fall-through
// PORTS
//  clk           in   1          system clock, rising edge
//  rst           in   1          asynchronous reset, active high
//  wr            in   1          write request
//  datain        in   WIDTH      write data
//  rd            in   1          read request
//  dataout       out  WIDTH      read data
//  full          out  1          count == DEPTH
//  empty         out  1          count == 0
//  almost_full   out  1          count >= AF_THRESH
//  almost_empty  out  1          count <= AE_THRESH
//  count         out  ADDR_W+1   occupancy, 0..DEPTH (ADDR_W = clog2(DEPTH))
//  flush         in   1          synchronous clear of contents
//  clr_err       in   1          synchronous clear of sticky error flags
//  overflow      out  1          sticky: write attempted while full
//  underflow     out  1          sticky: read attempted while empty
// BEHAVIOUR
//  - Reset: wr/rd pointers 0, count 0, dataout 0, full 0, empty 1,
//    almost_empty 1, almost_full 0, overflow 0, underflow 0. Memory not cleared.
//  - Pointers are ADDR_W+1 bits; the extra MSB disambiguates full vs empty on wrap.
//  - Write accepted iff wr && !full. Read accepted iff rd && !empty.
//    Both evaluate against the pre-edge state.
//  - Simultaneous accepted wr+rd: count unchanged; both pointers advance.
//  - wr while full: write dropped, overflow set next edge.
//    This also holds when rd is high in the same cycle; the read still proceeds.
//  - rd while empty: no pointer move, dataout holds, underflow set next edge.
//    This also holds when wr is high in the same cycle; the write still proceeds.
//  - FWFT=0: dataout is registered and updates to the head word one cycle
//    after an accepted rd; otherwise it holds its value.
//  - FWFT=1: dataout = mem[rd_ptr] continuously; the word is valid whenever
//    empty==0, and an accepted rd pops it (next word visible after the edge).
//  - Flags and count are registered and decoded from pointer state only;
//    there is no combinational path from wr/rd to any flag.
//  - flush: pointers and count go to 0 at the next edge, flags return to reset
//    values, dataout holds. flush overrides wr/rd in the same cycle; no error is
//    flagged for a wr/rd masked by flush. Error flags are unaffected by flush.
//  - clr_err: clears overflow/underflow at the next edge. A new error in the
//    same cycle wins, so the flag stays set.
//  - rst mid-operation: all state returns to reset values immediately.
//    Partial words are discarded.
// STRUCTURE
//  - Shared package fifo_pkg: clog2 constant function and ADDR_W derivation.
//  - Sub-module sync_fifo_ram: 1-write/1-read dual-port array (WIDTH x DEPTH),
//    write on clk, asynchronous read port.
//  - Top level holds pointers, count, flag registers, output register and
//    error logic.
// TESTING (defaults WIDTH=8 DEPTH=16 AF=12 AE=2)
//  - Reset: rst=1 for 100 ns -> empty=1, almost_empty=1, count=0, dataout=0,
//    full=0, errors=0.
//  - Fill: write 0..15 -> count=16, full=1, almost_full from count 12;
//    a 17th wr sets overflow and the contents are unchanged.
//  - Drain (FWFT=0): 16 reads -> dataout 0..15, each one cycle after its rd;
//    empty=1 at end; a 17th rd sets underflow and dataout holds 15.
//  - Concurrent: with count=8, wr+rd for 40 cycles -> count stays 8, data order
//    preserved across pointer wrap.
//  - FWFT=1: write 0xA5 -> dataout=0xA5 with empty=0 before any rd; rd -> empty=1.
//  - Flush at count=10 with wr=1 -> count=0, empty=1, overflow=0;
//    clr_err+rd on empty -> underflow remains 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO family.
//   clog2  : ceiling log2, usable in constant expressions
//   addr_w : address width needed to index a FIFO of the given depth
package fifo_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int unsigned addr_w(input int unsigned depth);
        return clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_param: one synchronous write port, one
// asynchronous read port. Contents are not reset.
//   clk    in   write clock, rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
module sync_fifo_ram #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, optional first-word-fall-through, synchronous
// flush and sticky overflow/underflow flags.
//   clk, rst                  clock (rising) / async active-high reset
//   wr, datain                write request and data
//   rd, dataout               read request and data
//   full, empty               count == DEPTH / count == 0
//   almost_full, almost_empty count >= AF_THRESH / count <= AE_THRESH
//   count                     occupancy 0..DEPTH
//   flush                     synchronous clear of contents
//   clr_err                   synchronous clear of overflow/underflow
//   overflow, underflow       sticky error flags
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 12,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned FWFT      = 0,
    localparam int unsigned ADDR_W   = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [WIDTH-1:0]  datain,
    input  logic              rd,
    output logic [WIDTH-1:0]  dataout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    input  logic              flush,
    input  logic              clr_err,
    output logic              overflow,
    output logic              underflow
);

    typedef logic [ADDR_W:0] ptr_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam ptr_t DEPTH_C = ptr_t'(DEPTH);
    localparam ptr_t AF_C    = ptr_t'(AF_THRESH);
    localparam ptr_t AE_C    = ptr_t'(AE_THRESH);

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t cnt_q, cnt_d;
    logic full_q, full_d;
    logic empty_q, empty_d;
    logic af_q, af_d;
    logic ae_q, ae_d;
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;
    logic wr_ok, rd_ok;
    logic [WIDTH-1:0] rdata;

    // Acceptance uses the registered flags, i.e. the pre-edge state.
    assign wr_ok = wr & ~full_q & ~flush;
    assign rd_ok = rd & ~empty_q & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // Flags are decoded from the next pointer pair and registered, so no
        // wr/rd-to-flag combinational path exists at the outputs.
        cnt_d   = wr_ptr_d - rd_ptr_d;
        full_d  = (cnt_d == DEPTH_C);
        empty_d = (cnt_d == '0);
        af_d    = (cnt_d >= AF_C);
        ae_d    = (cnt_d <= AE_C);

        // A new error outranks clr_err; flush masks errors for that cycle.
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wr && full_q && !flush)  ovf_d = 1'b1;
        if (rd && empty_q && !flush) udf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    sync_fifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (datain),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (rdata)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word is always presented; a read simply advances past it.
        assign dataout = rdata;
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_ok) begin
                dout_q <= rdata;
            end
        end
        assign dataout = dout_q;
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
